osd_mam_wb_sram: RTL and testbench
==================================

Name: osd_mam_wb_sram

Overview:
- Wishbone classic slave memory sitting directly downstream of the MAM Wishbone master interface.
- Consumes its stb/cyc/we/addr/dat/sel cycles and returns ack/err and read data.
- Serves as on-chip debug-visible RAM and as the reference target for MAM bring-up.
- Supports byte selects, a configurable number of wait states, and an error response for out-of-window or misaligned accesses.

Parameters:
- DATA_WIDTH, 16: bus width in bits; 8, 16 or 32.
- ADDR_WIDTH, 32: byte address width.
- MEM_SIZE_BYTES, 1024: memory size in bytes; a power of two and a multiple of DATA_WIDTH/8.
- BASE_ADDR, 0: byte address of word 0; aligned to MEM_SIZE_BYTES.
- WAIT_CYCLES, 0: extra cycles inserted before ack/err; range 0..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cyc_i  in  1  bus cycle valid.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SW  byte selects; SW = DATA_WIDTH/8.
- cti_i  in  3  ignored; every access is treated as classic.
- bte_i  in  2  ignored.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- dat_o  out  DATA_WIDTH  read data.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, wait counter=0, ack_o=0, err_o=0, dat_o=0.
  - Memory contents are not reset.
- Request condition: req = cyc_i & stb_i.
- Address decode:
  - offset = addr_i - BASE_ADDR.
  - hit = addr_i >= BASE_ADDR, offset < MEM_SIZE_BYTES, and addr_i[log2(SW)-1:0]==0.
  - word index = offset >> log2(SW).
- State machine IDLE / WAIT / RESP:
  - IDLE: when req, latch we, word index, hit, dat_i and sel_i.
    - If WAIT_CYCLES==0, go to RESP.
    - Otherwise load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT:
    - If req drops, the access is aborted: return to IDLE with no write and no response.
    - Else if counter==0, go to RESP; else decrement the counter.
  - RESP: ack_o=hit or err_o=!hit, held for exactly one cycle; then unconditionally return to IDLE.
    - ack_o and err_o are registered (they reflect state==RESP) and are never both 1.
- Latency: the response appears WAIT_CYCLES+1 cycles after the cycle in which IDLE samples req. With WAIT_CYCLES=0 the peak rate is one transfer per 2 cycles.
- Back-to-back transfers:
  - The master may keep stb_i high after ack (burst with new addr/data).
  - The RESP cycle never samples a new request; IDLE samples it on the following cycle.
- Write:
  - Committed at the clock edge that ends the RESP cycle, only when hit.
  - Only bytes with sel=1 are updated; sel=0 leaves the byte unchanged.
  - No write occurs on err or abort.
- Read:
  - The synchronous RAM read of the latched index is issued on the edge entering RESP.
  - dat_o is valid during the ack cycle; dat_o=0 on err.
  - dat_o holds its last value outside response cycles.
- Address and data are taken only at the IDLE capture. Changes on addr_i/dat_i during WAIT are ignored.
- Reset asserted mid-access: state returns to IDLE immediately and ack_o/err_o drop. A pending write is lost.

Decomposition:
- Package osd_mam_wb_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - function sel_width(DATA_WIDTH);
  - constant for the maximum WAIT_CYCLES (15).
- Sub-module osd_mam_wb_sram_ram:
  - single-port synchronous RAM, DEPTH = MEM_SIZE_BYTES/SW words, with per-byte write enables;
  - no reset on storage.

Test Plan:
1. DATA_WIDTH=16, WAIT_CYCLES=0: write 0xBEEF to 0x10 with sel=2'b11, then read 0x10 -> ack exactly 1 cycle after each sample, read dat_o=0xBEEF.
2. Byte select: word 0x20=0x1234, write 0xAB00 with sel=2'b10, read back -> 0xAB34.
3. WAIT_CYCLES=3, burst of 4 reads starting at 0x0 with stb held high -> each ack 4 cycles after its sample, one idle cycle between acks, addresses 0,2,4,6 returned in order.
4. Access 0x400 (out of window) and 0x11 (misaligned) -> err_o pulses once, ack_o=0, memory unchanged, dat_o=0.
5. WAIT_CYCLES=5, write to 0x8 with stb dropped after 2 cycles -> no ack/err, a later read of 0x8 returns the old value.
6. Assert rst_ni=0 during WAIT -> ack_o/err_o low in the same cycle, state IDLE, and a fresh read completes normally after release.

Source files
------------

// File: rtl/osd_mam_wb_pkg.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_pkg
//
// Shared definitions for the MAM Wishbone SRAM target:
//   - state_e          : IDLE / WAIT / RESP states of the slave FSM
//   - MAX_WAIT_CYCLES  : largest supported number of inserted wait states
//   - sel_width()      : number of byte lanes for a given data width
// ---------------------------------------------------------------------------
package osd_mam_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned MAX_WAIT_CYCLES = 15;

    // One select line per byte lane of the data bus.
    function automatic int unsigned sel_width(input int unsigned dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/osd_mam_wb_sram_ram.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_sram_ram
//
// Single-port synchronous RAM with per-byte write enables. Storage is not
// reset; contents are undefined until written.
//
// Ports:
//   clk_i    : clock
//   addr_i   : word index used for both read and write
//   re_i     : load rdata_o with the addressed word on the next edge
//   we_i     : write the selected bytes of wdata_i on the next edge
//   be_i     : byte enables, one per byte lane
//   wdata_i  : write data
//   rdata_o  : registered read data
// ---------------------------------------------------------------------------
module osd_mam_wb_sram_ram
    import osd_mam_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned IDXW       = 9
) (
    input  logic                    clk_i,
    input  logic [IDXW-1:0]         addr_i,
    input  logic                    re_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int SW = int'(sel_width(DATA_WIDTH));

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes and the synchronous read share one address. The
    // controller never asks for both in the same cycle, so read data never
    // has to choose between old and new contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < SW; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/osd_mam_wb_sram.sv
// ---------------------------------------------------------------------------
// osd_mam_wb_sram
//
// Wishbone classic slave memory placed behind the MAM Wishbone master.
// Supports byte selects, WAIT_CYCLES inserted wait states and an error
// response for out-of-window or misaligned accesses.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   cyc_i   : bus cycle valid
//   stb_i   : strobe
//   we_i    : 1 = write, 0 = read
//   addr_i  : byte address
//   dat_i   : write data
//   sel_i   : byte selects
//   cti_i   : cycle type, ignored (all accesses are classic)
//   bte_i   : burst type, ignored
//   ack_o   : normal termination, one cycle
//   err_o   : error termination, one cycle
//   dat_o   : read data, valid during ack, zero during err, held otherwise
// ---------------------------------------------------------------------------
module osd_mam_wb_sram
    import osd_mam_wb_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 16,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           MEM_SIZE_BYTES = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           WAIT_CYCLES    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int unsigned SW    = sel_width(DATA_WIDTH);
    localparam int unsigned LSB   = $clog2(SW);
    localparam int unsigned DEPTH = MEM_SIZE_BYTES / SW;
    localparam int unsigned IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW  = $clog2(MAX_WAIT_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] MEM_SIZE_A = ADDR_WIDTH'(MEM_SIZE_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(SW - 1);

    logic                  req;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  addrHit;
    logic [IDXW-1:0]       reqIdx;

    state_e                state_q, state_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic                  reqWe_q, reqWe_d;
    logic                  reqHit_q, reqHit_d;
    logic [IDXW-1:0]       reqIdx_q, reqIdx_d;
    logic [DATA_WIDTH-1:0] reqData_q, reqData_d;
    logic [SW-1:0]         reqSel_q, reqSel_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] holdData_q;

    logic                  ramRe;
    logic                  ramWe;
    logic [DATA_WIDTH-1:0] ramRdata;

    logic                  unusedInputs;

    assign unusedInputs = ^{cti_i, bte_i};

    // Address decode. The window check and the alignment check are both
    // needed for a hit; anything else is answered with err_o.
    assign req     = cyc_i & stb_i;
    assign offset  = addr_i - BASE_ADDR;
    assign addrHit = (addr_i >= BASE_ADDR) && (offset < MEM_SIZE_A) &&
                     ((addr_i & ALIGN_MASK) == '0);
    assign reqIdx  = offset[IDXW+LSB-1:LSB];

    // Next-state logic. A request is only ever captured in IDLE, which is
    // why a master holding stb_i through the response cycle is sampled one
    // cycle after the ack. Dropping the request while waiting abandons the
    // access without any side effect.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reqWe_d   = reqWe_q;
        reqHit_d  = reqHit_q;
        reqIdx_d  = reqIdx_q;
        reqData_d = reqData_q;
        reqSel_d  = reqSel_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    reqWe_d   = we_i;
                    reqHit_d  = addrHit;
                    reqIdx_d  = reqIdx;
                    reqData_d = dat_i;
                    reqSel_d  = sel_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        count_d = CNTW'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d = RESP;
                end else begin
                    count_d = count_q - CNTW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered terminations follow the state that is about to be entered,
    // so ack_o/err_o line up exactly with the RESP cycle.
    assign ack_d = (state_d == RESP) && reqHit_d;
    assign err_d = (state_d == RESP) && !reqHit_d;

    // The RAM read is launched on the edge entering RESP; the write is
    // committed on the edge leaving RESP. These never overlap, and in both
    // cases the index to use is the next captured index.
    assign ramRe = (state_d == RESP) && reqHit_d;
    assign ramWe = (state_q == RESP) && reqWe_q && reqHit_q;

    // Read data is shown only during a response: RAM data on ack, zero on
    // err. Otherwise the value of the last response is held.
    assign dat_o = (state_q == RESP) ? (reqHit_q ? ramRdata : '0) : holdData_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

    // State, counter, captured request and response registers. Reset puts
    // the controller back in IDLE immediately, which also discards a write
    // that was waiting for the end of its response cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reqWe_q    <= 1'b0;
            reqHit_q   <= 1'b0;
            reqIdx_q   <= '0;
            reqData_q  <= '0;
            reqSel_q   <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            holdData_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            reqWe_q    <= reqWe_d;
            reqHit_q   <= reqHit_d;
            reqIdx_q   <= reqIdx_d;
            reqData_q  <= reqData_d;
            reqSel_q   <= reqSel_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            if (state_q == RESP) begin
                holdData_q <= dat_o;
            end
        end
    end

    osd_mam_wb_sram_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDXW       (IDXW)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (reqIdx_d),
        .re_i    (ramRe),
        .we_i    (ramWe),
        .be_i    (reqSel_q),
        .wdata_i (reqData_q),
        .rdata_o (ramRdata)
    );

endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// ---------------------------------------------------------------------------
// tb_osd_mam_wb_sram
//
// Three instances with different wait-state counts and base addresses share
// one set of bus signals; only the selected instance sees cyc asserted.
// A byte-accurate memory image per instance predicts read data, and the
// latency of each access is predicted from its wait-state count.
// ---------------------------------------------------------------------------
module tb_osd_mam_wb_sram;

    localparam int DW = 16;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cyc, stb, we;
    logic [31:0] addr;
    logic [15:0] wdat;
    logic [1:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    int          tgt;

    logic        ackV [3];
    logic        errV [3];
    logic [15:0] datV [3];

    logic [15:0] model [3][512];
    int          testsRun;
    int          testsFailed;
    bit          burst;

    always #5 clk = ~clk;

    osd_mam_wb_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MEM_SIZE_BYTES(1024),
                      .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc && (tgt == 0)), .stb_i(stb),
        .we_i(we), .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti),
        .bte_i(bte), .ack_o(ackV[0]), .err_o(errV[0]), .dat_o(datV[0]));

    osd_mam_wb_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MEM_SIZE_BYTES(1024),
                      .BASE_ADDR(32'h400), .WAIT_CYCLES(3)) dut1 (
        .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc && (tgt == 1)), .stb_i(stb),
        .we_i(we), .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti),
        .bte_i(bte), .ack_o(ackV[1]), .err_o(errV[1]), .dat_o(datV[1]));

    osd_mam_wb_sram #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .MEM_SIZE_BYTES(1024),
                      .BASE_ADDR(32'h0), .WAIT_CYCLES(5)) dut2 (
        .clk_i(clk), .rst_ni(rstN), .cyc_i(cyc && (tgt == 2)), .stb_i(stb),
        .we_i(we), .addr_i(addr), .dat_i(wdat), .sel_i(sel), .cti_i(cti),
        .bte_i(bte), .ack_o(ackV[2]), .err_o(errV[2]), .dat_o(datV[2]));

    // Configuration of each instance as seen by the reference model.
    function automatic int waitOf(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 5;
    endfunction

    function automatic logic [31:0] baseOf(input int k);
        return (k == 1) ? 32'h400 : 32'h0;
    endfunction

    function automatic bit isHit(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - baseOf(k);
        return (a >= baseOf(k)) && (off < 32'd1024) && (a[0] == 1'b0);
    endfunction

    function automatic int wordOf(input int k, input logic [31:0] a);
        logic [31:0] off;
        off = a - baseOf(k);
        return int'(off[9:1]);
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One Wishbone access. Called at a negedge with the bus idle or, when a
    // burst is continuing, during the previous ack cycle. keep leaves cyc/stb
    // asserted after the response for the next access of a burst.
    task automatic applyStimulus(input int k, input bit w, input logic [31:0] a,
                                 input logic [15:0] d, input logic [1:0] s,
                                 input bit keep);
        int          cycles;
        int          expCycles;
        bit          got;
        bit          h;
        int          idx;
        logic [15:0] seen;
        h         = isHit(k, a);
        idx       = wordOf(k, a);
        expCycles = waitOf(k) + 1 + (burst ? 1 : 0);
        tgt  = k;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        addr = a;
        wdat = d;
        sel  = s;
        cti  = 3'($urandom);
        bte  = 2'($urandom);
        cycles = 0;
        got    = 1'b0;
        seen   = '0;
        while (!got && cycles < expCycles + 8) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (ackV[k] || errV[k]) got = 1'b1;
        end
        checkOutput("latency", cycles, expCycles);
        if (got) begin
            checkOutput("ackErrExcl", 32'(ackV[k] & errV[k]), 0);
            checkOutput("ack", 32'(ackV[k]), 32'(h));
            checkOutput("err", 32'(errV[k]), 32'(!h));
            if (!h) checkOutput("errData", datV[k], 0);
            else if (!w) checkOutput("readData", datV[k], model[k][idx]);
            seen = datV[k];
            if (w && h) begin
                for (int b = 0; b < 2; b++)
                    if (s[b]) model[k][idx][b*8 +: 8] = d[b*8 +: 8];
            end
        end
        burst = keep && got;
        if (!keep) begin
            cyc = 1'b0;
            stb = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("pulseAck", 32'(ackV[k]), 0);
            checkOutput("pulseErr", 32'(errV[k]), 0);
            if (got) checkOutput("holdData", datV[k], seen);
        end
    endtask

    // Write that is abandoned two cycles after being sampled; no response
    // may ever appear and the model is left untouched.
    task automatic applyAbort(input int k, input logic [31:0] a, input logic [15:0] d);
        tgt  = k;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        addr = a;
        wdat = d;
        sel  = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abortNoRespEarly", 32'(ackV[k] | errV[k]), 0);
        end
        cyc = 1'b0;
        stb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("abortNoResp", 32'(ackV[k] | errV[k]), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] base;
        int          r;
        bit          keep;
        testsRun    = 0;
        testsFailed = 0;
        burst       = 1'b0;
        rstN = 1'b0;
        cyc  = 1'b0;
        stb  = 1'b0;
        we   = 1'b0;
        addr = '0;
        wdat = '0;
        sel  = '0;
        cti  = '0;
        bte  = '0;
        tgt  = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("resetAck", 32'(ackV[k]), 0);
            checkOutput("resetErr", 32'(errV[k]), 0);
            checkOutput("resetDat", datV[k], 0);
        end
        rstN = 1'b1;
        @(negedge clk);

        // Give the first 64 words of every instance a known value.
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 64; i++)
                applyStimulus(k, 1'b1, baseOf(k) + 32'(2 * i), 16'($urandom), 2'b11, 1'b0);

        // Full-word write then read back, no wait states.
        applyStimulus(0, 1'b1, 32'h10, 16'hBEEF, 2'b11, 1'b0);
        applyStimulus(0, 1'b0, 32'h10, 16'h0000, 2'b00, 1'b0);
        checkOutput("beefRead", datV[0], 16'hBEEF);

        // Upper-byte-only write merges with the existing low byte.
        applyStimulus(0, 1'b1, 32'h20, 16'h1234, 2'b11, 1'b0);
        applyStimulus(0, 1'b1, 32'h20, 16'hAB00, 2'b10, 1'b0);
        applyStimulus(0, 1'b0, 32'h20, 16'h0000, 2'b00, 1'b0);
        checkOutput("byteSelRead", datV[0], 16'hAB34);

        // Burst of four reads with stb held high, three wait states.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1'b0, 32'h400 + 32'(2 * i), 16'h0, 2'b00, i != 3);

        // Out-of-window and misaligned accesses, then confirm no damage.
        applyStimulus(0, 1'b1, 32'h400, 16'h5555, 2'b11, 1'b0);
        applyStimulus(0, 1'b1, 32'h11,  16'h6666, 2'b11, 1'b0);
        applyStimulus(0, 1'b0, 32'h400, 16'h0, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 32'h10,  16'h0, 2'b00, 1'b0);
        applyStimulus(1, 1'b1, 32'h3FE, 16'h7777, 2'b11, 1'b0);
        applyStimulus(1, 1'b0, 32'h800, 16'h0, 2'b00, 1'b0);

        // Abandoned write during the wait states.
        applyAbort(2, 32'h8, ~model[2][4]);
        applyStimulus(2, 1'b0, 32'h8, 16'h0, 2'b00, 1'b0);

        // Reset while waiting, then a normal read.
        tgt  = 2;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b0;
        addr = 32'h6;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rstN = 1'b0;
        #1;
        checkOutput("rstWaitAck", 32'(ackV[2]), 0);
        checkOutput("rstWaitErr", 32'(errV[2]), 0);
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN  = 1'b1;
        burst = 1'b0;
        applyStimulus(2, 1'b0, 32'h6, 16'h0, 2'b00, 1'b0);

        // Reset during the ack of a write: the write must be lost.
        tgt  = 0;
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = 1'b1;
        addr = 32'h30;
        wdat = ~model[0][24];
        sel  = 2'b11;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstRespAckBefore", 32'(ackV[0]), 1);
        rstN = 1'b0;
        #1;
        checkOutput("rstRespAckAfter", 32'(ackV[0]), 0);
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 1'b0, 32'h30, 16'h0, 2'b00, 1'b0);

        // Randomized traffic, bursts kept within one instance.
        for (int k = 0; k < 3; k++) begin
            base = baseOf(k);
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = base + 32'h400 + 32'(2 * $urandom_range(0, 15));
                else if (r == 1) a = base + 32'(2 * $urandom_range(0, 63) + 1);
                else if (r == 2 && base != 0) a = base - 32'(2 * $urandom_range(1, 8));
                else             a = base + 32'(2 * $urandom_range(0, 63));
                keep = ($urandom_range(0, 2) == 0) && (i != 39);
                applyStimulus(k, 1'($urandom), a, 16'($urandom), 2'($urandom), keep);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
